ascon_perm_core: RTL and testbench
==================================

// Module: ascon_perm_core
// PURPOSE
//  Iterative Ascon permutation p^a / p^b engine: holds 320-bit state (x0..x4), and per round applies
//  constant addition -> S_Box_Parallel -> Linear_Diffusion, then registers the result. Sits directly
//  upstream of the substitution layer (produces its p0..p4) and consumes the diffusion layer's outputs.
//  Serves the mode controller (init/AD/data/final phases) via a start/done handshake.
// PARAMETERS
//  W        64   lane width; fixed at 64 for Ascon, exposed only for sub-module parameter passthrough
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request permutation; accepted only when ready=1
//  rounds_sel  in   2      00=12 rounds, 01=8, 10=6, 11=12; sampled at accepted start
//  state_in    in   5xW    x0..x4 input state; sampled at accepted start
//  ready       out  1      core can accept start (FSM in IDLE or DONE)
//  busy        out  1      permutation in progress (FSM in RUN)
//  done        out  1      one-cycle pulse: state_out holds final permuted state
//  state_out   out  5xW    current state register; valid result from done until next accepted start
// BEHAVIOUR
//  - Reset: FSM=IDLE, state_reg=0, idx=0, ready=1, busy=0, done=0, state_out=0.
//  - FSM IDLE -> RUN on start; RUN -> DONE after last round; DONE -> IDLE, or DONE -> RUN if start.
//  - Accept cycle: state_reg<=state_in; idx<=12-n (n from rounds_sel: 12->0, 8->4, 6->6).
//  - RUN, each cycle: state_reg<=round(state_reg, RC[idx]); idx<=idx+1; when idx==11 go DONE.
//  - round(): x2[7:0] ^= RC[idx] (other bits untouched), then S-box, then diffusion, no other logic.
//  - RC[0..11] = F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B (hex).
//  - Latency: start accepted at cycle t -> done=1 at cycle t+n+1 (13/9/7 cycles for 12/8/6 rounds).
//  - start while busy=1: ignored, no effect on state or count. start during DONE: accepted (back-to-back,
//    done still pulses that cycle; state_out shows old result that cycle, new load next cycle).
//  - state_in / rounds_sel changes while busy: ignored.
//  - rst mid-operation: abort immediately, all registers to reset values, no done pulse.
//  - state_out is state_reg directly (no output mux); intermediate rounds are visible but not valid.
// CONFIGURATION
//  - ASCON_PERM_UNROLL2_EN defined: two round() instances chained per cycle (RC[idx], RC[idx+1]);
//    idx += 2; DONE when idx==10 at RUN; latency t+n/2+1 (7/5/4). All n are even, no odd-tail case.
//  - Undefined: one round per cycle as above. Port list and handshake identical in both builds.
// STRUCTURE
//  - ascon_pkg: state_t typedef (logic [4:0][63:0]), RC table localparam array, rounds_sel enum
//    and rounds_sel->start index function, FSM state enum {IDLE, RUN, DONE}.
//  - Sub-module ascon_round: combinational const-add + S_Box_Parallel + Linear_Diffusion wrapper,
//    ports state_i, rc_i[7:0], state_o; instantiated once (or twice under ASCON_PERM_UNROLL2_EN).
//  - ascon_perm_core: FSM, idx counter (4 bits), state register, handshake outputs.
// TESTING
//  - Reset: hold rst 2 cycles -> ready=1, busy=0, done=0, state_out=0; start under rst has no effect.
//  - p^12: state_in = Ascon-128 init (x0=80400C0600000000, key/nonce 0), rounds_sel=00 -> done at t+13,
//    state_out == golden C model; done exactly 1 cycle wide.
//  - p^8 and p^6 on random state: done at t+9 / t+7; RC sequence seen at ascon_round rc_i is
//    B4..4B (8) and 96..4B (6); state_out == model.
//  - start pulsed every cycle during RUN with changed state_in -> ignored; result equals single-run model.
//  - Back-to-back: start in DONE cycle with new state -> second done at t'+n+1, both results correct.
//  - rst asserted mid-RUN (cycle t+5) -> next cycle all outputs reset, no done; new start runs clean.
//  - Rebuild with ASCON_PERM_UNROLL2_EN: repeat p^12/p^8/p^6 -> same results, done at t+7/t+5/t+4.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types, round constants and helpers for the Ascon permutation core
package ascon_pkg;
    localparam int LANE_W = 64;
    typedef logic [4:0][63:0] state_t;
    typedef enum logic [1:0] {RS_12 = 2'b00, RS_8 = 2'b01, RS_6 = 2'b10, RS_12B = 2'b11} rounds_sel_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
    localparam logic [11:0][7:0] RC = {8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96,
                                       8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
    function automatic logic [3:0] start_idx(input logic [1:0] sel);
        return (sel == RS_8) ? 4'd4 : (sel == RS_6) ? 4'd6 : 4'd0;
    endfunction
    // Indices past the table occur only outside RUN, where the round result is discarded
    function automatic logic [7:0] rc_at(input logic [3:0] i);
        return (i > 4'd11) ? 8'h00 : RC[i];
    endfunction
endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon round (constant add, 5-bit S-box layer, linear diffusion)
module ascon_round import ascon_pkg::*; #(
    parameter int W = LANE_W
) (
    input  logic [4:0][W-1:0] state_i,
    input  logic [7:0]        rc_i,
    output logic [4:0][W-1:0] state_o
);
    logic [4:0][W-1:0] s, u, v;
    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input int r);
        return (x >> r) | (x << (W - r));
    endfunction
    assign s = {state_i[4] ^ state_i[3], state_i[3], state_i[2] ^ state_i[1] ^ {{(W-8){1'b0}}, rc_i},
                state_i[1], state_i[0] ^ state_i[4]};
    for (genvar g = 0; g < 5; g++) begin : g_chi
        assign u[g] = s[g] ^ (~s[(g + 1) % 5] & s[(g + 2) % 5]);
    end
    assign v = {u[4], u[3] ^ u[2], ~u[2], u[1] ^ u[0], u[0] ^ u[4]};
    assign state_o = {v[4] ^ ror(v[4], 7) ^ ror(v[4], 41),
                      v[3] ^ ror(v[3], 10) ^ ror(v[3], 17),
                      v[2] ^ ror(v[2], 1) ^ ror(v[2], 6),
                      v[1] ^ ror(v[1], 61) ^ ror(v[1], 39),
                      v[0] ^ ror(v[0], 19) ^ ror(v[0], 28)};
endmodule

// File: rtl/ascon_perm_core.sv
// ascon_perm_core: iterative Ascon p^12/p^8/p^6 engine with start/done handshake.
// Define ASCON_PERM_UNROLL2_EN to evaluate two chained rounds per cycle.
module ascon_perm_core import ascon_pkg::*; #(
    parameter int W = LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        rounds_sel,
    input  logic [4:0][W-1:0] state_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [4:0][W-1:0] state_out
);
    fsm_e              fsm_q;
    logic [3:0]        idx_q;
    logic [4:0][W-1:0] state_q, state_d;
`ifdef ASCON_PERM_UNROLL2_EN
    localparam logic [3:0] STEP = 4'd2, LAST = 4'd10;
    logic [4:0][W-1:0] mid;
    ascon_round #(.W(W)) u_r0 (.state_i(state_q), .rc_i(rc_at(idx_q)), .state_o(mid));
    ascon_round #(.W(W)) u_r1 (.state_i(mid), .rc_i(rc_at(idx_q + 4'd1)), .state_o(state_d));
`else
    localparam logic [3:0] STEP = 4'd1, LAST = 4'd11;
    ascon_round #(.W(W)) u_r0 (.state_i(state_q), .rc_i(rc_at(idx_q)), .state_o(state_d));
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            idx_q   <= '0;
            state_q <= '0;
        end else if (fsm_q == RUN) begin
            state_q <= state_d;
            idx_q   <= idx_q + STEP;
            if (idx_q == LAST) fsm_q <= DONE;
        end else if (start) begin
            state_q <= state_in;
            idx_q   <= start_idx(rounds_sel);
            fsm_q   <= RUN;
        end else begin
            fsm_q <= IDLE;
        end
    end
    assign busy      = (fsm_q == RUN);
    assign ready     = !busy;
    assign done      = (fsm_q == DONE);
    assign state_out = state_q;
endmodule

// File: tb/tb_ascon_perm_core.sv
// tb_ascon_perm_core: scoreboard bench for ascon_perm_core against an S-box-table reference model.
// Honours ASCON_PERM_UNROLL2_EN for the expected latency and constant sequence.
module tb_ascon_perm_core;
    import ascon_pkg::*;
`ifdef ASCON_PERM_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    typedef struct {state_t st; int cyc;} exp_t;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0] rounds_sel = 2'b00;
    state_t     state_in = '0, state_out;
    logic       ready, busy, done;
    int         cyc = 0, ntests = 0, nfail = 0, rc_base = 0, rc_off = 0;
    logic       prev_done = 1'b0;
    exp_t       sbq[$];
    byte unsigned sbox[32] = '{8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
                               8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
                               8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
                               8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};
    int rot1[5] = '{19, 61, 1, 10, 7};
    int rot2[5] = '{28, 39, 6, 17, 41};

    ascon_perm_core dut (
        .clk(clk), .rst(rst), .start(start), .rounds_sel(rounds_sel), .state_in(state_in),
        .ready(ready), .busy(busy), .done(done), .state_out(state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rc_tb(input int k);
        return 8'((15 - k) << 4 | k);
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic state_t model_round(input state_t x, input logic [7:0] rc);
        state_t y;
        logic [4:0] o;
        x[2][7:0] = x[2][7:0] ^ rc;
        for (int b = 0; b < 64; b++) begin
            o = 5'(sbox[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}]);
            for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
        end
        for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], rot1[i]) ^ rotr(y[i], rot2[i]);
        return x;
    endfunction

    function automatic state_t model_perm(input state_t st, input int n);
        for (int k = 12 - n; k < 12; k++) st = model_round(st, rc_tb(k));
        return st;
    endfunction

    function automatic state_t rnd_state();
        state_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic int nrounds(input logic [1:0] sel);
        return (sel == 2'b01) ? 8 : (sel == 2'b10) ? 6 : 12;
    endfunction

    // Returns during the first RUN cycle with start already dropped
    task automatic do_start(input logic [1:0] sel, input state_t st);
        int n = nrounds(sel);
        @(negedge clk);
        start = 1'b1;
        rounds_sel = sel;
        state_in = st;
        rc_base = 12 - n;
        sbq.push_back('{model_perm(st, n), cyc + n / STEP + 1});
        @(negedge clk);
        start = 1'b0;
        rounds_sel = 2'($urandom);
        state_in = rnd_state();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            check("timeout", 320'(sbq.size()), 320'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            check("rc0", 320'(dut.u_r0.rc_i), 320'(rc_tb(rc_base + rc_off * STEP)));
`ifdef ASCON_PERM_UNROLL2_EN
            check("rc1", 320'(dut.u_r1.rc_i), 320'(rc_tb(rc_base + rc_off * STEP + 1)));
`endif
            rc_off = rc_off + 1;
        end else begin
            rc_off = 0;
        end
        if (done) begin
            check("done_width", 320'(prev_done), 320'd0);
            if (sbq.size() == 0) begin
                check("spurious_done", 320'(done), 320'd0);
            end else begin
                e = sbq.pop_front();
                check("result", state_out, e.st);
                check("latency", 320'(cyc), 320'(e.cyc));
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        state_t st;
        int runc;
        start = 1'b1;
        state_in = rnd_state();
        repeat (2) @(negedge clk);
        check("rst_ready", 320'(ready), 320'd1);
        check("rst_busy", 320'(busy), 320'd0);
        check("rst_done", 320'(done), 320'd0);
        check("rst_state", state_out, 320'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 320'(busy), 320'd0);

        st = '0;
        st[0] = 64'h80400C0600000000;
        do_start(2'b00, st);
        drain(40);
        do_start(2'b01, rnd_state());
        drain(40);
        do_start(2'b10, rnd_state());
        drain(40);
        do_start(2'b11, rnd_state());
        drain(40);

        do_start(2'b01, rnd_state());
        runc = 8 / STEP;
        for (int i = 0; i < runc; i++) begin
            start = 1'b1;
            state_in = rnd_state();
            rounds_sel = 2'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        drain(40);

        do_start(2'b00, rnd_state());
        repeat (12 / STEP - 1) @(negedge clk);
        do_start(2'b10, rnd_state());
        drain(60);

        do_start(2'b00, rnd_state());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        check("abort_ready", 320'(ready), 320'd1);
        check("abort_busy", 320'(busy), 320'd0);
        check("abort_done", 320'(done), 320'd0);
        check("abort_state", state_out, 320'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_start(2'b01, rnd_state());
        drain(40);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
